// File: rtl/ariane_pkg.sv
// Shared frontend/predictor types: the predictor training update and the
// per-prediction record held while a branch is in flight.
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
        logic            mispredict;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_pred_entry_t;

endpackage

// File: rtl/bht_pred_fifo.sv
// In-order store of outstanding predictions; pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module bht_pred_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  bht_pred_entry_t            wdata_i,
    output bht_pred_entry_t            rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    bht_pred_entry_t mem_q [DEPTH];
    bht_pred_entry_t mem_d [DEPTH];
    logic            do_push, do_pop;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        // Flush wins over any pop/push in the same cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bht_update_queue.sv
// Matches in-order branch resolutions against the oldest outstanding
// prediction and emits a registered training update plus a mispredict count.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        debug_mode_i,
    input  logic                        pred_valid_i,
    input  logic [63:0]                 pred_pc_i,
    input  logic                        pred_taken_i,
    output logic                        pred_ready_o,
    input  logic                        res_valid_i,
    input  logic [63:0]                 res_pc_i,
    input  logic                        res_taken_i,
    output bht_update_t                 bht_update_o,
    output logic [CNT_WIDTH-1:0]        mispredict_cnt_o,
    output logic                        pc_mismatch_o,
    output logic [$clog2(DEPTH):0]      occupancy_o
);
    bht_pred_entry_t      head, wdata;
    logic                 full, empty, push, pop, mispredict, pc_diff;
    bht_update_t          update_q, update_d;
    logic                 pc_mismatch_q, pc_mismatch_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    bht_pred_fifo #(.DEPTH(DEPTH)) i_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     (wdata),
        .rdata_o     (head),
        .full_o      (full),
        .empty_o     (empty),
        .occupancy_o (occupancy_o)
    );

    assign pred_ready_o = !full;

    always_comb begin
        wdata.pc    = pred_pc_i;
        wdata.taken = pred_taken_i;
        push        = pred_valid_i && !full && !flush_i;
        // Debug-mode resolutions still retire their prediction.
        pop         = res_valid_i && !empty;
        pc_diff     = (head.pc != res_pc_i);
        // An unpredicted branch is treated as predicted not-taken.
        mispredict  = pop ? ((head.taken != res_taken_i) || pc_diff) : res_taken_i;

        update_d      = '0;
        pc_mismatch_d = pop && pc_diff;
        cnt_d         = cnt_q;
        if (res_valid_i) begin
            update_d.valid      = !debug_mode_i;
            update_d.pc         = res_pc_i;
            update_d.taken      = res_taken_i;
            update_d.mispredict = mispredict;
            if (!debug_mode_i && mispredict && (cnt_q != {CNT_WIDTH{1'b1}}))
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            update_q      <= '0;
            pc_mismatch_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            update_q      <= update_d;
            pc_mismatch_q <= pc_mismatch_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bht_update_o     = update_q;
    assign pc_mismatch_o    = pc_mismatch_q;
    assign mispredict_cnt_o = cnt_q;

endmodule
